// File: rtl/fp_align_stage.sv
// fp_align_stage
// Two-stage pipelined exponent-alignment unit for the single-precision FP adder.
// Takes the larger-magnitude (big_in) and smaller-magnitude (small_in) operands
// from the swap stage. It unpacks them, finds the exponent difference and
// right-shifts the small significand with guard/round/sticky bits.
//
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   big_in, small_in     IEEE-754 single operands, |big_in| >= |small_in|
//   in_valid, in_ready   upstream handshake (in_ready is combinational from out_ready)
//   out_valid, out_ready downstream handshake
//   exp_out              effective exponent of big_in
//   mant_big             {hidden, frac, 3'b000}
//   mant_small           aligned small significand, bit 0 = sticky
//   sign_big, eff_sub    sign of big_in, and sign_big ^ sign_small
//   special              big_in is Inf/NaN (exponent all ones)
module fp_align_stage #(
  parameter int MANT_W = 27
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       big_in,
  input  logic [31:0]       small_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        exp_out,
  output logic [MANT_W-1:0] mant_big,
  output logic [MANT_W-1:0] mant_small,
  output logic              sign_big,
  output logic              eff_sub,
  output logic              special
);

  localparam int GRS_W = MANT_W - 24;
  localparam logic [7:0] SHIFT_LIMIT = 8'(MANT_W);

  // Stage 1 registers
  logic        s1_v;
  logic        s1_sign_big;
  logic        s1_sign_small;
  logic [23:0] s1_sig_big;
  logic [23:0] s1_sig_small;
  logic [7:0]  s1_exp;
  logic [7:0]  s1_diff;
  logic        s1_special;

  // Stage 2 valid; the S2 data registers are the outputs themselves
  logic s2_v;

  logic s1_load;
  logic s2_load;

  // Unpack: denormals (exp == 0) have no hidden bit and an effective exponent of 1
  logic [7:0]  big_exp;
  logic [7:0]  small_exp;
  logic [7:0]  big_eff_exp;
  logic [7:0]  small_eff_exp;
  logic [23:0] big_sig;
  logic [23:0] small_sig;

  assign big_exp       = big_in[30:23];
  assign small_exp     = small_in[30:23];
  assign big_eff_exp   = (big_exp == 8'd0) ? 8'd1 : big_exp;
  assign small_eff_exp = (small_exp == 8'd0) ? 8'd1 : small_exp;
  assign big_sig       = {big_exp != 8'd0, big_in[22:0]};
  assign small_sig     = {small_exp != 8'd0, small_in[22:0]};

  // Elastic pipeline control; S1 may refill in the same cycle it hands off to S2
  assign s2_load   = s1_v & (~s2_v | out_ready);
  assign in_ready  = ~s1_v | s2_load;
  assign s1_load   = in_valid & in_ready;
  assign out_valid = s2_v;

  // Alignment shift. The mask collects the bits pushed below bit 0 so they can
  // be folded into the sticky bit. Beyond MANT_W everything is shifted out and
  // only "was the significand non-zero" survives as sticky.
  logic [MANT_W-1:0] ext;
  logic [MANT_W-1:0] shifted;
  logic [MANT_W-1:0] lost_mask;
  logic              lost;
  logic [MANT_W-1:0] aligned;

  assign ext       = {s1_sig_small, {GRS_W{1'b0}}};
  assign shifted   = ext >> s1_diff;
  assign lost_mask = ~({MANT_W{1'b1}} << s1_diff);
  assign lost      = |(ext & lost_mask);
  assign aligned   = (s1_diff < SHIFT_LIMIT) ?
                     {shifted[MANT_W-1:1], shifted[0] | lost} :
                     {{(MANT_W-1){1'b0}}, |s1_sig_small};

  // Stage 1: register unpacked operands and the exponent difference
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v          <= 1'b0;
      s1_sign_big   <= 1'b0;
      s1_sign_small <= 1'b0;
      s1_sig_big    <= '0;
      s1_sig_small  <= '0;
      s1_exp        <= '0;
      s1_diff       <= '0;
      s1_special    <= 1'b0;
    end else begin
      if (s1_load) begin
        s1_v <= 1'b1;
      end else if (s2_load) begin
        s1_v <= 1'b0;
      end
      if (s1_load) begin
        s1_sign_big   <= big_in[31];
        s1_sign_small <= small_in[31];
        s1_sig_big    <= big_sig;
        s1_sig_small  <= small_sig;
        s1_exp        <= big_eff_exp;
        s1_diff       <= big_eff_exp - small_eff_exp;
        s1_special    <= (big_exp == 8'hFF);
      end
    end
  end

  // Stage 2: register the aligned result; data holds while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_v       <= 1'b0;
      exp_out    <= '0;
      mant_big   <= '0;
      mant_small <= '0;
      sign_big   <= 1'b0;
      eff_sub    <= 1'b0;
      special    <= 1'b0;
    end else begin
      if (s2_load) begin
        s2_v <= 1'b1;
      end else if (out_ready) begin
        s2_v <= 1'b0;
      end
      if (s2_load) begin
        exp_out    <= s1_exp;
        mant_big   <= {s1_sig_big, {GRS_W{1'b0}}};
        mant_small <= aligned;
        sign_big   <= s1_sign_big;
        eff_sub    <= s1_sign_big ^ s1_sign_small;
        special    <= s1_special;
      end
    end
  end

endmodule
